fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the pipelined core: owns the PC, drives the instruction-memory address, and loads the IF/ID pipeline register. Consumes the `stall` signal from the hazard detection unit, and the taken-branch redirect from the execute stage. Holds the front end frozen on stall and inserts bubbles on redirect. Stops fetching after a HALT instruction until redirected or reset.

## Interface
- `PC_W`, default 8: PC and instruction-memory address width. Word-addressed.
- `INSTR_W`, default 16: instruction width.
- `clk` in, 1: the single clock. All state updates on its rising edge.
- `rst` in, 1: reset. Synchronous and active-high.
- `stall` in, 1: from the hazard unit. Freezes the PC and IF/ID.
- `branch_taken` in, 1: redirect request from execute.
- `branch_target` in, PC_W: redirect address.
- `imem_addr` out, PC_W: equals the current PC. Combinational from the PC register.
- `imem_data` in, INSTR_W: instruction at `imem_addr`. Combinational-read memory, so it is valid in the same cycle.
- `if_id_instr` out, INSTR_W: registered instruction to decode.
- `if_id_pc1` out, PC_W: registered PC+1 of that instruction.
- `if_id_valid` out, 1: IF/ID holds a real instruction.
- `halted` out, 1: high while in the HALTED state.
- `stall_cnt` out, 16: stall-cycle counter. See Configuration.

## Operation
- FSM has two states: RUN and HALTED. Reset state is RUN.
- Per-cycle priority: `rst` first, then `branch_taken`, then `stall`, then the state action.
- `rst`:
  - pc, IF/ID instr, IF/ID pc1 and `if_id_valid` go to 0.
  - State goes to RUN; `halted`=0; `stall_cnt`=0.
- `branch_taken` (any state, regardless of `stall`):
  - pc ← `branch_target`.
  - `if_id_instr` ← NOP (all zeros); `if_id_valid` ← 0.
  - State ← RUN.
  - Reason: the branch is older than the stalled instruction, so the redirect wins.
- `stall` without a branch:
  - pc and all IF/ID fields hold their values.
  - State holds.
- RUN with no stall and no branch:
  - pc ← pc+1, wrapping modulo 2^PC_W (0xFF → 0x00 at the default width).
  - `if_id_instr` ← `imem_data`; `if_id_pc1` ← pc+1; `if_id_valid` ← 1.
  - If `imem_data[INSTR_W-1:INSTR_W-4]` equals HALT_OP (4'hF): the HALT itself is issued with valid=1 and the state goes to HALTED.
- HALTED with no stall and no branch:
  - pc holds.
  - `if_id_instr` ← NOP; `if_id_valid` ← 0.
- `halted` is a registered output; it is 1 exactly while the state is HALTED.

## Timing
- Fetch-to-IF/ID latency is one cycle. The instruction at pc appears on `if_id_instr` after the next rising edge.
- The branch penalty is one bubble inside this block. A redirect in cycle N means `imem_addr`=target in cycle N+1 and `if_id_valid`=0 in cycle N+1.
- Stall takes effect at the edge it is sampled. A stall asserted for k cycles holds the outputs for exactly k edges.
- `rst` asserted mid-stall or mid-halt overrides everything at that edge.
- HALT fetched at edge E: `halted`=1 after E, and no further valid instruction is issued after E.

## Configuration
- Macro: `FETCH_STALL_CNT_EN`.
- Defined:
  - `stall_cnt` increments on each edge where `stall`=1, `branch_taken`=0, `rst`=0 and the state is RUN.
  - It saturates at 16'hFFFF and clears on `rst`.
- Undefined: `stall_cnt` is tied to 0 and the counter logic is not built. The port remains, so the interface is stable.

## Structure
- Shared package `fetch_pkg` holds:
  - the NOP constant (all zeros);
  - HALT_OP = 4'hF and the opcode field position;
  - the state enum (RUN, HALTED).
- Sub-module `if_id_reg`: the IF/ID pipeline register. Inputs are load, flush and hold controls; outputs are instr, pc1 and valid. It is reused by later pipeline-register variants.
- PC logic, FSM and counter stay in `fetch_unit`.

## Test plan
- Reset with imem[0]=16'h1234 → after the first edge: `if_id_instr`=16'h1234, `if_id_pc1`=1, `if_id_valid`=1, `imem_addr`=1.
- `stall`=1 for 3 cycles at pc=5 → `imem_addr` stays at 5 and IF/ID is unchanged for 3 edges; `stall_cnt`=3 when the macro is defined, 0 when it is not.
- `stall`=1 and `branch_taken`=1 with target 8'h40 in the same cycle → next cycle `imem_addr`=8'h40, `if_id_valid`=0, `if_id_instr`=0.
- Fetch 16'hF000 at pc=7 → issued with valid=1; `halted`=1; pc stays at 8; subsequent `if_id_valid`=0. Then `branch_taken` with target 8'h10 → `halted`=0 and fetch resumes at 8'h10.
- Sequential fetch from pc=8'hFE → `imem_addr` goes 8'hFF, then 8'h00; `if_id_pc1`=8'h00 for the instruction fetched at 8'hFF.
- Assert `rst` while HALTED with `stall`=1 → all outputs are 0 after the edge and the state is RUN.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: NOP word, HALT opcode, FSM states.
// No logic of its own; latency and backpressure are properties of the users.
// Opcode occupies the top OP_W bits of every instruction word.
package fetch_pkg;

    // Widest instruction word supported by NOP_WORD; users slice the low bits.
    localparam int MAX_INSTR_W = 64;

    // Bubble inserted into IF/ID: all zeros.
    localparam logic [MAX_INSTR_W-1:0] NOP_WORD = '0;

    // Opcode field: the OP_W most significant bits of the instruction.
    localparam int          OP_W    = 4;
    localparam logic [3:0]  HALT_OP = 4'hF;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register holding instruction, PC+1 and a valid flag.
// Latency: one cycle from load to outputs.
// Priority per edge: rst, flush (bubble, pc1 kept), hold (freeze), load.
module if_id_reg
    import fetch_pkg::*;
#(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               flush_i,
    input  logic               hold_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [PC_W-1:0]    pc1_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [PC_W-1:0]    pc1_o,
    output logic               valid_o
);

    logic [INSTR_W-1:0] instr_q;
    logic [PC_W-1:0]    pc1_q;
    logic               valid_q;

    // Register update: a flush turns the slot into a bubble but leaves pc1 untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q <= '0;
            pc1_q   <= '0;
            valid_q <= 1'b0;
        end else if (flush_i) begin
            instr_q <= NOP_WORD[INSTR_W-1:0];
            valid_q <= 1'b0;
        end else if (hold_i) begin
            instr_q <= instr_q;
            pc1_q   <= pc1_q;
            valid_q <= valid_q;
        end else if (load_i) begin
            instr_q <= instr_i;
            pc1_q   <= pc1_i;
            valid_q <= 1'b1;
        end
    end

    assign instr_o = instr_q;
    assign pc1_o   = pc1_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, addresses imem, loads IF/ID; HALT parks the front end.
// Latency: imem word appears on if_id_instr one edge after its address is driven.
// Stall freezes PC and IF/ID; redirect overrides stall and inserts one bubble.
// Optional macro FETCH_STALL_CNT_EN builds a saturating stall-cycle counter.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [PC_W-1:0]    if_id_pc1,
    output logic               if_id_valid,
    output logic               halted,
    output logic [15:0]        stall_cnt
);

    state_t          state_q;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_inc;
    logic            halted_q;
    logic            is_halt;
    logic            fetch_go;
    logic            ifid_flush;

    // Next sequential PC wraps naturally at 2^PC_W.
    assign pc_inc  = pc_q + 1'b1;
    assign is_halt = (imem_data[INSTR_W-1 -: OP_W] == HALT_OP);

    // A real fetch happens only when running, unstalled and not redirected.
    assign fetch_go   = !branch_taken && !stall && (state_q == RUN);
    // Bubble on redirect, and on every unstalled cycle spent halted.
    assign ifid_flush = branch_taken || (!stall && (state_q == HALTED));

    // PC and RUN/HALTED state machine; halted is kept as its own register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= '0;
            state_q  <= RUN;
            halted_q <= 1'b0;
        end else if (branch_taken) begin
            pc_q     <= branch_target;
            state_q  <= RUN;
            halted_q <= 1'b0;
        end else if (!stall) begin
            case (state_q)
                RUN: begin
                    pc_q <= pc_inc;
                    if (is_halt) begin
                        state_q  <= HALTED;
                        halted_q <= 1'b1;
                    end
                end
                HALTED: begin
                    pc_q <= pc_q;
                end
                default: begin
                    state_q  <= RUN;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    if_id_reg #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_if_id (
        .clk     (clk),
        .rst     (rst),
        .load_i  (fetch_go),
        .flush_i (ifid_flush),
        .hold_i  (stall),
        .instr_i (imem_data),
        .pc1_i   (pc_inc),
        .instr_o (if_id_instr),
        .pc1_o   (if_id_pc1),
        .valid_o (if_id_valid)
    );

    assign imem_addr = pc_q;
    assign halted    = halted_q;

`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] stall_cnt_d;

    // Count stalled cycles while running; saturate instead of wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && !branch_taken && (state_q == RUN) && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Counter register, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios, then random stall/branch/reset traffic.
// Every cycle all outputs are compared to a behavioural model of the fetch rules.
// Stall counter expectation follows FETCH_STALL_CNT_EN.
module tb_fetch_unit;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               stall;
    logic               branch_taken;
    logic [PC_W-1:0]    branch_target;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic [INSTR_W-1:0] if_id_instr;
    logic [PC_W-1:0]    if_id_pc1;
    logic               if_id_valid;
    logic               halted;
    logic [15:0]        stall_cnt;

    logic [INSTR_W-1:0] imem [0:(1<<PC_W)-1];

    int total = 0;
    int bad   = 0;

    // Reference model state
    int m_pc;
    int m_instr;
    int m_pc1;
    int m_valid;
    int m_halted;
    int m_cnt;

    always #5 clk = ~clk;

    assign imem_data = imem[imem_addr];

    fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .if_id_instr   (if_id_instr),
        .if_id_pc1     (if_id_pc1),
        .if_id_valid   (if_id_valid),
        .halted        (halted),
        .stall_cnt     (stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_cnt();
`ifdef FETCH_STALL_CNT_EN
        return m_cnt;
`else
        return 0;
`endif
    endfunction

    // Advance the model by one edge using the inputs that were present at it.
    task automatic model_edge(input int r, input int s, input int b, input int tgt);
        int word;
        if (r != 0) begin
            m_pc = 0; m_instr = 0; m_pc1 = 0; m_valid = 0; m_halted = 0; m_cnt = 0;
        end else if (b != 0) begin
            m_pc = tgt; m_instr = 0; m_valid = 0; m_halted = 0;
        end else if (s != 0) begin
            if (m_halted == 0 && m_cnt < 65535) m_cnt++;
        end else if (m_halted == 0) begin
            word    = int'(imem[m_pc]);
            m_instr = word;
            m_pc1   = (m_pc + 1) % 256;
            m_valid = 1;
            m_pc    = m_pc1;
            if ((word >> 12) == 15) m_halted = 1;
        end else begin
            m_instr = 0;
            m_valid = 0;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".addr"},   32'(imem_addr),   32'(m_pc));
        check({tag, ".instr"},  32'(if_id_instr), 32'(m_instr));
        check({tag, ".pc1"},    32'(if_id_pc1),   32'(m_pc1));
        check({tag, ".valid"},  32'(if_id_valid), 32'(m_valid));
        check({tag, ".halted"}, 32'(halted),      32'(m_halted));
        check({tag, ".cnt"},    32'(stall_cnt),   32'(exp_cnt()));
    endtask

    // One clock: drive inputs, take the edge, advance model, sample #1 later.
    task automatic step(input string tag, input logic r, input logic s,
                        input logic b, input logic [PC_W-1:0] tgt);
        rst = r; stall = s; branch_taken = b; branch_target = tgt;
        @(posedge clk);
        model_edge(int'(r), int'(s), int'(b), int'(tgt));
        #1;
        compare_all(tag);
    endtask

    function automatic logic [INSTR_W-1:0] rnd_non_halt();
        logic [INSTR_W-1:0] w;
        w = INSTR_W'($urandom);
        if (w[15:12] == 4'hF) w[15] = 1'b0;
        return w;
    endfunction

    initial begin
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        for (int i = 0; i < 256; i++) imem[i] = rnd_non_halt();
        imem[0] = 16'h1234;
        imem[7] = 16'hF000;
        m_pc = 0; m_instr = 0; m_pc1 = 0; m_valid = 0; m_halted = 0; m_cnt = 0;

        // Reset state
        step("rst", 1'b1, 1'b0, 1'b0, 8'h00);
        check("rst_valid", 32'(if_id_valid), 32'd0);

        // First fetch after reset
        step("first", 1'b0, 1'b0, 1'b0, 8'h00);
        check("first_instr", 32'(if_id_instr), 32'h1234);
        check("first_pc1",   32'(if_id_pc1),   32'd1);
        check("first_addr",  32'(imem_addr),   32'd1);

        // Three-cycle stall at pc=5
        step("to5", 1'b0, 1'b0, 1'b1, 8'h05);
        for (int k = 0; k < 3; k++) begin
            step("stall", 1'b0, 1'b1, 1'b0, 8'h00);
            check("stall_addr", 32'(imem_addr), 32'd5);
        end
`ifdef FETCH_STALL_CNT_EN
        check("stall_cnt3", 32'(stall_cnt), 32'd3);
`else
        check("stall_cnt0", 32'(stall_cnt), 32'd0);
`endif

        // Branch wins over stall
        step("br_stall", 1'b0, 1'b1, 1'b1, 8'h40);
        check("br_addr",  32'(imem_addr),   32'h40);
        check("br_valid", 32'(if_id_valid), 32'd0);
        check("br_instr", 32'(if_id_instr), 32'd0);

        // HALT at pc=7
        step("to7", 1'b0, 1'b0, 1'b1, 8'h07);
        step("halt", 1'b0, 1'b0, 1'b0, 8'h00);
        check("halt_instr",  32'(if_id_instr), 32'hF000);
        check("halt_valid",  32'(if_id_valid), 32'd1);
        check("halt_flag",   32'(halted),      32'd1);
        check("halt_addr",   32'(imem_addr),   32'd8);
        step("halted1", 1'b0, 1'b0, 1'b0, 8'h00);
        check("halted_valid", 32'(if_id_valid), 32'd0);
        check("halted_addr",  32'(imem_addr),   32'd8);
        step("resume", 1'b0, 1'b0, 1'b1, 8'h10);
        check("resume_halted", 32'(halted),    32'd0);
        check("resume_addr",   32'(imem_addr), 32'h10);
        step("resume_f", 1'b0, 1'b0, 1'b0, 8'h00);
        check("resume_valid", 32'(if_id_valid), 32'd1);

        // PC wrap
        step("toFE", 1'b0, 1'b0, 1'b1, 8'hFE);
        step("wrapFF", 1'b0, 1'b0, 1'b0, 8'h00);
        check("wrap_addrFF", 32'(imem_addr), 32'hFF);
        step("wrap00", 1'b0, 1'b0, 1'b0, 8'h00);
        check("wrap_addr00", 32'(imem_addr), 32'h00);
        check("wrap_pc1",    32'(if_id_pc1), 32'h00);

        // Reset while halted and stalled
        step("to7b", 1'b0, 1'b0, 1'b1, 8'h07);
        step("halt2", 1'b0, 1'b0, 1'b0, 8'h00);
        step("rst_h", 1'b1, 1'b1, 1'b0, 8'h00);
        check("rsth_halted", 32'(halted),    32'd0);
        check("rsth_addr",   32'(imem_addr), 32'd0);
        step("rsth_run", 1'b0, 1'b0, 1'b0, 8'h00);
        check("rsth_valid", 32'(if_id_valid), 32'd1);

        // Random traffic; ~1/16 of words are HALTs
        for (int i = 0; i < 256; i++) imem[i] = INSTR_W'($urandom);
        for (int n = 0; n < 3000; n++) begin
            step("rnd",
                 ($urandom_range(0, 99) < 2),
                 ($urandom_range(0, 99) < 25),
                 ($urandom_range(0, 99) < 8),
                 PC_W'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
